sram_multiport: RTL and testbench

- Generic on-chip SRAM model with 1–2 asynchronous (combinational) read ports and an optional synchronous write port.
- One configurable core serves as graph memory (2R, 128b), input memory (1R, 8b), output memory (1R1W, 16b) and working memory (2R1W, 128b) around the Bellman-Ford engine.
- Storage array is named Register so benches can preload or dump it hierarchically (readmemh/writememh).

---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_rd_port.sv | 42 ++++
 rtl/sram_roles.sv | 36 +++
 rtl/sram_multiport.sv | 82 ++++++++
 tb/tb_sram_multiport.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared sizes and constants for the SRAM model and its role wrappers
package sram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DEPTH_DEF  = 8192;

  localparam int GRAPH_W  = 128;
  localparam int INPUT_W  = 8;
  localparam int OUTPUT_W = 16;
  localparam int WORK_W   = 128;

  // Unreached-node distance marker used by the engine in 16b output words
  localparam logic [OUTPUT_W-1:0] INF_WORD = 16'hFFFF;

endpackage

// File: rtl/sram_rd_port.sv
// rtl/sram_rd_port.sv - one combinational read port: range check plus optional write-first bypass
// Optional: SRAM_WRITE_FORWARD_EN returns in-flight write data on a same-address read.
module sram_rd_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int DEPTH      = 8192,
  parameter int IDX_W      = 13
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]      mem_idx_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  fwd_en_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic in_range;
  logic fwd_hit;

  assign in_range  = {1'b0, addr_i} < DEPTH_L;
  assign mem_idx_o = addr_i[IDX_W-1:0];

`ifdef SRAM_WRITE_FORWARD_EN
  // in_range also covers the write address whenever the two match
  assign fwd_hit = fwd_en_i && (addr_i == waddr_i);
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_en_i, waddr_i, wdata_i};
  assign fwd_hit    = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    if (in_range) begin
      rdata_o = fwd_hit ? wdata_i : mem_data_i;
    end
  end

endmodule

// File: rtl/sram_roles.sv
// rtl/sram_roles.sv - parameter-only wrappers binding sram_multiport to each memory role
module sram_graph_mem import sram_pkg::*; (
  input  logic clock, input logic reset, input logic WE,
  input  logic [ADDR_W_DEF-1:0] WriteAddress, input logic [GRAPH_W-1:0] WriteBus,
  input  logic [ADDR_W_DEF-1:0] ReadAddress1, output logic [GRAPH_W-1:0] ReadBus1,
  input  logic [ADDR_W_DEF-1:0] ReadAddress2, output logic [GRAPH_W-1:0] ReadBus2
);
  sram_multiport #(.DATA_WIDTH(GRAPH_W), .NUM_RD(2), .HAS_WR(0)) u_mem (.*);
endmodule

module sram_input_mem import sram_pkg::*; (
  input  logic clock, input logic reset, input logic WE,
  input  logic [ADDR_W_DEF-1:0] WriteAddress, input logic [INPUT_W-1:0] WriteBus,
  input  logic [ADDR_W_DEF-1:0] ReadAddress1, output logic [INPUT_W-1:0] ReadBus1,
  input  logic [ADDR_W_DEF-1:0] ReadAddress2, output logic [INPUT_W-1:0] ReadBus2
);
  sram_multiport #(.DATA_WIDTH(INPUT_W), .NUM_RD(1), .HAS_WR(0)) u_mem (.*);
endmodule

module sram_output_mem import sram_pkg::*; (
  input  logic clock, input logic reset, input logic WE,
  input  logic [ADDR_W_DEF-1:0] WriteAddress, input logic [OUTPUT_W-1:0] WriteBus,
  input  logic [ADDR_W_DEF-1:0] ReadAddress1, output logic [OUTPUT_W-1:0] ReadBus1,
  input  logic [ADDR_W_DEF-1:0] ReadAddress2, output logic [OUTPUT_W-1:0] ReadBus2
);
  sram_multiport #(.DATA_WIDTH(OUTPUT_W), .NUM_RD(1), .HAS_WR(1)) u_mem (.*);
endmodule

module sram_work_mem import sram_pkg::*; (
  input  logic clock, input logic reset, input logic WE,
  input  logic [ADDR_W_DEF-1:0] WriteAddress, input logic [WORK_W-1:0] WriteBus,
  input  logic [ADDR_W_DEF-1:0] ReadAddress1, output logic [WORK_W-1:0] ReadBus1,
  input  logic [ADDR_W_DEF-1:0] ReadAddress2, output logic [WORK_W-1:0] ReadBus2
);
  sram_multiport #(.DATA_WIDTH(WORK_W), .NUM_RD(2), .HAS_WR(1)) u_mem (.*);
endmodule

// File: rtl/sram_multiport.sv
// rtl/sram_multiport.sv - generic SRAM, 1-2 async read ports, optional sync write port
// Optional: SRAM_WRITE_FORWARD_EN enables write-first bypass on the read ports.
module sram_multiport
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = OUTPUT_W,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int NUM_RD     = 1,
  parameter int HAS_WR     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteBus,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  output logic [DATA_WIDTH-1:0] ReadBus1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [DATA_WIDTH-1:0] ReadBus2
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  if (NUM_RD < 1 || NUM_RD > 2) begin : g_bad_num_rd
    $fatal(1, "sram_multiport: NUM_RD must be 1 or 2");
  end
  if (64'(DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
    $fatal(1, "sram_multiport: DEPTH exceeds 2**ADDR_WIDTH");
  end

  // Kept under this exact name so benches can reach it hierarchically
  logic [DATA_WIDTH-1:0] Register [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];
  logic                  fwd_en;

  assign rd_addr[0] = ReadAddress1;
  assign rd_addr[1] = ReadAddress2;
  assign fwd_en     = (HAS_WR != 0) && reset && WE;

  if (HAS_WR != 0) begin : g_wr
    always_ff @(posedge clock) begin
      if (reset && WE && ({1'b0, WriteAddress} < DEPTH_L)) begin
        Register[WriteAddress[IDX_W-1:0]] <= WriteBus;
      end
    end
  end else begin : g_rom
    logic unused_wr;
    assign unused_wr = ^{clock, reset, WE, WriteAddress, WriteBus};
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [IDX_W-1:0] idx;
    sram_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
    ) u_rd_port (
      .addr_i     (rd_addr[gi]),
      .mem_idx_o  (idx),
      .mem_data_i (Register[idx]),
      .fwd_en_i   (fwd_en),
      .waddr_i    (WriteAddress),
      .wdata_i    (WriteBus),
      .rdata_o    (rd_data[gi])
    );
  end

  if (NUM_RD == 1) begin : g_one_rd
    logic unused_rd2;
    assign unused_rd2 = ^ReadAddress2;
    assign rd_data[1] = '0;
  end

  assign ReadBus1 = rd_data[0];
  assign ReadBus2 = rd_data[1];

endmodule

// File: tb/tb_sram_multiport.sv
// tb/tb_sram_multiport.sv - scoreboard bench for sram_multiport (default, 128b 2R, 4096-deep builds)
module tb_sram_multiport;

`ifdef SRAM_WRITE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [127:0] WORD_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] WORD_B = 128'hDEADBEEF_CAFEF00D_00112233_44556677;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_we;
  logic [12:0] a_wa, a_ra1, a_ra2;
  logic [15:0] a_wb, a_rb1, a_rb2;

  logic         w_we;
  logic [12:0]  w_wa, w_ra1, w_ra2;
  logic [127:0] w_wb, w_rb1, w_rb2;

  logic        d_we;
  logic [12:0] d_wa, d_ra1, d_ra2;
  logic [15:0] d_wb, d_rb1, d_rb2;

  sram_multiport dut (
    .clock(clk), .reset(rst_n), .WE(a_we), .WriteAddress(a_wa), .WriteBus(a_wb),
    .ReadAddress1(a_ra1), .ReadBus1(a_rb1), .ReadAddress2(a_ra2), .ReadBus2(a_rb2)
  );

  sram_multiport #(.DATA_WIDTH(128), .ADDR_WIDTH(13), .DEPTH(8192), .NUM_RD(2), .HAS_WR(1)) dut_w (
    .clock(clk), .reset(rst_n), .WE(w_we), .WriteAddress(w_wa), .WriteBus(w_wb),
    .ReadAddress1(w_ra1), .ReadBus1(w_rb1), .ReadAddress2(w_ra2), .ReadBus2(w_rb2)
  );

  sram_multiport #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .DEPTH(4096), .NUM_RD(1), .HAS_WR(1)) dut_d (
    .clock(clk), .reset(rst_n), .WE(d_we), .WriteAddress(d_wa), .WriteBus(d_wb),
    .ReadAddress1(d_ra1), .ReadBus1(d_rb1), .ReadAddress2(d_ra2), .ReadBus2(d_rb2)
  );

  typedef struct {
    int           sel;
    logic [127:0] exp;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [127:0] pick(input int sel);
    case (sel)
      0:       return {112'b0, a_rb1};
      1:       return w_rb1;
      2:       return w_rb2;
      3:       return {112'b0, d_rb1};
      4:       return {112'b0, a_rb2};
      default: return 'x;
    endcase
  endfunction

  task automatic push_exp(input int sel, input logic [127:0] v, input string n);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Read ports are combinational, so the monitor samples on the falling edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [127:0] act;
      e   = sb_q.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    a_we = 0; a_wa = 0; a_wb = 0; a_ra1 = 0; a_ra2 = 0;
    w_we = 0; w_wa = 0; w_wb = 0; w_ra1 = 0; w_ra2 = 0;
    d_we = 0; d_wa = 0; d_wb = 0; d_ra1 = 13'd4096; d_ra2 = 0;
    push_exp(4, 128'h0, "rd2_unused_zero");
    push_exp(3, 128'h0, "oor_read_in_reset");
    cyc();
    cyc();

    rst_n = 1'b1;
    a_we = 1; a_wa = 13'd5; a_wb = 16'h1234;
    cyc();
    a_ra1 = 13'd5; a_wa = 13'h0010; a_wb = 16'hBEEF;
    push_exp(0, 128'h1234, "read_addr5");
    cyc();
    a_we = 0; a_wb = 16'h0000; a_ra1 = 13'h0010;
    push_exp(0, 128'hBEEF, "write_visible");
    cyc();
    push_exp(0, 128'hBEEF, "hold_after_we_low");
    a_we = 1; a_wa = 13'd3; a_wb = 16'h0007;
    cyc();
    rst_n = 1'b0; a_wb = 16'hFFFF;
    cyc();
    a_we = 0; a_ra1 = 13'd3;
    push_exp(0, 128'h0007, "reset_blocks_write");
    cyc();
    rst_n = 1'b1; a_we = 1;
    cyc();
    a_wa = 13'd7; a_wb = 16'h0001;
    push_exp(0, 128'hFFFF, "write_after_release");
    cyc();
    a_wb = 16'h0002; a_ra1 = 13'd7;
    push_exp(0, FWD ? 128'h0002 : 128'h0001, "raw_before_edge");
    cyc();
    a_we = 0;
    push_exp(0, 128'h0002, "raw_after_edge");
    cyc();

    w_we = 1; w_wa = 13'd0; w_wb = WORD_A;
    cyc();
    w_wa = 13'd8191; w_wb = WORD_B;
    cyc();
    w_we = 0; w_ra1 = 13'd0; w_ra2 = 13'd8191;
    push_exp(1, WORD_A, "dual_rd1_addr0");
    push_exp(2, WORD_B, "dual_rd2_addr8191");
    cyc();
    w_ra1 = 13'd8191;
    push_exp(1, WORD_B, "same_addr_rd1");
    push_exp(2, WORD_B, "same_addr_rd2");
    cyc();

    d_we = 1; d_wa = 13'd0; d_wb = 16'h0AAA;
    cyc();
    d_wa = 13'd4095; d_wb = 16'h7777;
    cyc();
    d_wa = 13'd4096; d_wb = 16'h5555;
    cyc();
    d_we = 0;
    push_exp(3, 128'h0, "oor_read_zero");
    cyc();
    d_ra1 = 13'd0;
    push_exp(3, 128'h0AAA, "no_wrap_addr0");
    cyc();
    d_ra1 = 13'd4095;
    push_exp(3, 128'h7777, "last_word");
    cyc();

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
